// File: rtl/ram_dump_ctrl_pkg.sv
// Shared definitions for the post-run RAM dump sequencer: FSM states,
// UART payload width and word/byte geometry.
package ram_dump_ctrl_pkg;

    localparam int unsigned BYTE_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } dump_state_t;

    function automatic int unsigned bytes_per_word(input int unsigned data_length);
        return data_length / BYTE_BITS;
    endfunction

endpackage

// File: rtl/ram_dump_ctrl_word_byte_serializer.sv
// Holds one RAM word and walks its bytes MS byte first; the top FSM loads a
// word, then steps the byte index on each accepted UART completion.
module word_byte_serializer
    import ram_dump_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic [DATA_LENGTH-1:0] i_word,
    input  logic                   i_step,
    output logic [BYTE_BITS-1:0]   o_tx_data,
    output logic                   o_last
);

    localparam int unsigned BPW   = bytes_per_word(DATA_LENGTH);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [BPW-1:0][BYTE_BITS-1:0] word_q;
    logic [IDX_W-1:0]              idx_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (i_load) begin
            word_q <= i_word;
            idx_q  <= IDX_W'(BPW - 1);
        end else if (i_step) begin
            idx_q  <= idx_q - 1'b1;
        end
    end

    // Byte lane only moves on load/step, so the UART sees it stable for a whole frame.
    always_comb begin
        o_tx_data = word_q[idx_q];
        o_last    = (idx_q == '0);
    end

endmodule

// File: rtl/ram_dump_ctrl.sv
// Post-run RAM dump sequencer: on a CPU halt edge it takes the RAM read port,
// reads words 0..DUMP_WORDS-1 and streams each to the UART, MS byte first.
module ram_dump_ctrl
    import ram_dump_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 16,
    parameter int unsigned ADDR_LENGTH = 11,
    parameter int unsigned DUMP_WORDS  = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_halt,
    output logic                   o_ram_grant,
    output logic [ADDR_LENGTH-1:0] o_ram_addr,
    input  logic [DATA_LENGTH-1:0] i_ram_data,
    output logic [BYTE_BITS-1:0]   o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [ADDR_LENGTH-1:0] LAST_WORD = ADDR_LENGTH'(DUMP_WORDS - 1);

    dump_state_t            state_q, state_d;
    logic                   halt_q;
    logic                   halt_rise;
    logic [ADDR_LENGTH-1:0] word_idx;
    logic                   ser_last;
    logic                   ser_step;

    // halt_q resets high so a halt already asserted at reset release is not an edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            halt_q    <= 1'b1;
            halt_rise <= 1'b0;
            word_idx  <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= i_halt;
            halt_rise <= i_halt & ~halt_q;
            if (state_q == ST_IDLE)
                word_idx <= '0;
            else if (state_q == ST_NEXT && i_halt && word_idx != LAST_WORD)
                word_idx <= word_idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (halt_rise) state_d = ST_READ;
            ST_READ:  state_d = i_halt ? ST_LATCH : ST_IDLE;
            ST_LATCH: state_d = i_halt ? ST_SEND : ST_IDLE;
            ST_SEND:  state_d = i_halt ? ST_WAIT : ST_IDLE;
            // Abort is deferred until the frame completes.
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (!i_halt)       state_d = ST_IDLE;
                    else if (ser_last) state_d = ST_NEXT;
                    else               state_d = ST_SEND;
                end
            end
            ST_NEXT: begin
                if (!i_halt)                    state_d = ST_IDLE;
                else if (word_idx == LAST_WORD) state_d = ST_DONE;
                else                            state_d = ST_READ;
            end
            ST_DONE:  if (!i_halt) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ram_grant = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_tx_start  = 1'b0;
        o_ram_addr  = '0;
        ser_step    = (state_q == ST_WAIT) && i_tx_done && i_halt && !ser_last;
        unique case (state_q)
            ST_READ, ST_LATCH, ST_WAIT, ST_NEXT: begin
                o_ram_grant = 1'b1;
                o_busy      = 1'b1;
                o_ram_addr  = word_idx;
            end
            ST_SEND: begin
                o_ram_grant = 1'b1;
                o_busy      = 1'b1;
                o_ram_addr  = word_idx;
                o_tx_start  = 1'b1;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    word_byte_serializer #(
        .DATA_LENGTH (DATA_LENGTH)
    ) u_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (state_q == ST_LATCH),
        .i_word    (i_ram_data),
        .i_step    (ser_step),
        .o_tx_data (o_tx_data),
        .o_last    (ser_last)
    );

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Directed bench for ram_dump_ctrl with a two-word dump, a one-cycle RAM model
// and a hand-driven UART done pulse ten cycles after each start.
module tb_ram_dump_ctrl;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        halt     = 1'b1;
    logic        tx_done  = 1'b0;
    logic        grant;
    logic [10:0] addr;
    logic [15:0] ram_data = '0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        done;
    logic [15:0] ram [2];
    int          total     = 0;
    int          bad       = 0;
    int          start_cnt = 0;

    ram_dump_ctrl #(
        .DATA_LENGTH (16),
        .ADDR_LENGTH (11),
        .DUMP_WORDS  (2)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_halt      (halt),
        .o_ram_grant (grant),
        .o_ram_addr  (addr),
        .i_ram_data  (ram_data),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_done   (tx_done),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= ram[addr[0]];
    always @(posedge clk) if (tx_start === 1'b1) start_cnt <= start_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_txdata"}, tx_data, 0);
        check({tag, "_start"}, tx_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Entered just after the edge that put the DUT in SEND; leaves just after
    // the edge sampling the done pulse plus (gap-1) more edges.
    task automatic frame(input logic [7:0] exp, input logic [10:0] exp_addr,
                         input bit spur, input int gap);
        bit stable = 1'b1;
        check("start", tx_start, 1);
        check("tx_data", tx_data, exp);
        check("addr", addr, exp_addr);
        if (spur) tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tx_data !== exp || tx_start !== 1'b0 || grant !== 1'b1) stable = 1'b0;
            tick();
        end
        if (tx_data !== exp || tx_start !== 1'b0) stable = 1'b0;
        check("frame_stable", stable, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 1; i < gap; i++) tick();
    endtask

    initial begin
        ram[0] = 16'hA55A;
        ram[1] = 16'h1234;

        // Reset held with halt high, then released with halt still high.
        tick(); tick(); tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rel_busy", busy, 0);
        check("rel_grant", grant, 0);

        // Spurious done in IDLE.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check("idle_spur_start", tx_start, 0);
        check("idle_spur_busy", busy, 0);

        // Basic dump with latency check and spurious done in the first SEND.
        halt = 1'b0;
        tick(); tick();
        halt = 1'b1;
        tick(); tick(); tick();
        check("lat_start_early", tx_start, 0);
        tick();
        check("lat_busy", busy, 1);
        frame(8'hA5, 11'd0, 1'b1, 1);
        frame(8'h5A, 11'd0, 1'b0, 4);
        frame(8'h12, 11'd1, 1'b0, 1);
        frame(8'h34, 11'd1, 1'b0, 0);
        check("done_early", done, 0);
        tick();
        check("done_set", done, 1);
        check("done_busy", busy, 0);
        check("done_grant", grant, 0);
        check("start_count_dump", start_cnt, 4);
        tick(); tick(); tick();
        check("done_held", done, 1);
        halt = 1'b0;
        tick();
        check("done_clear", done, 0);

        // Abort during the WAIT of byte 2.
        tick();
        halt = 1'b1;
        tick(); tick(); tick(); tick();
        frame(8'hA5, 11'd0, 1'b0, 1);
        check("abort_start", tx_start, 1);
        check("abort_data", tx_data, 8'h5A);
        tick();
        halt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_wait_busy", busy, 1);
        check("abort_wait_grant", grant, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("abort_grant", grant, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 20; i++) tick();
        check("abort_start_count", start_cnt, 6);

        // Async reset during LATCH of word 1, then restart from address 0.
        halt = 1'b1;
        tick(); tick(); tick(); tick();
        frame(8'hA5, 11'd0, 1'b0, 1);
        frame(8'h5A, 11'd0, 1'b0, 0);
        tick(); tick();
        check("latch_busy", busy, 1);
        check("latch_addr", addr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("async");
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_count", start_cnt, 8);
        halt = 1'b0;
        tick(); tick();
        halt = 1'b1;
        tick(); tick(); tick();
        check("restart_early", tx_start, 0);
        tick();
        frame(8'hA5, 11'd0, 1'b0, 1);
        frame(8'h5A, 11'd0, 1'b0, 4);
        frame(8'h12, 11'd1, 1'b0, 1);
        frame(8'h34, 11'd1, 1'b0, 0);
        tick();
        check("restart_done", done, 1);
        check("restart_count", start_cnt, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
